// File: rtl/circular_right_shifter.sv
// Registered constant-distance rotate right by S bits; latency 1 cycle; no backpressure, accepts a word every cycle.
// Optional cross-check of the rotate against an OR-of-shifts form, enabled by defining ROTR_CROSS_CHECK_EN.
module circular_right_shifter #(
  parameter int N = 8,
  parameter int S = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  output logic         out_valid,
  output logic [N-1:0] res,
  output logic         mismatch
);

  // A zero or full-width distance leaves the concatenation slices empty.
  if (S <= 0 || S >= N) begin : g_bad_s
    $fatal(1, "circular_right_shifter: S must satisfy 0 < S < N");
  end

  logic [N-1:0] rot_cat;

  assign rot_cat = {a[S-1:0], a[N-1:S]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res <= rot_cat;
      end
    end
  end

`ifdef ROTR_CROSS_CHECK_EN
  logic [N-1:0] rot_or;

  // Shifts evaluate at width N, so the bits pushed past the MSB drop off.
  assign rot_or = (a >> S) | (a << (N - S));

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= in_valid && (rot_cat != rot_or);
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_circular_right_shifter.sv
// Bench for circular_right_shifter: N=8/S=3, N=16/S=1 and N=16/S=15 instances checked every cycle
// against a bitwise rotate model, plus directed vectors with fixed expected values.
module tb_circular_right_shifter;

  localparam int NI = 3;
  localparam int N_ARR [NI] = '{8, 16, 16};
  localparam int S_ARR [NI] = '{3, 1, 15};

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] iv;
  logic [15:0]   av [NI];
  logic [NI-1:0] ov;
  logic [NI-1:0] mm;
  logic [7:0]    r0;
  logic [15:0]   r1;
  logic [15:0]   r2;

  logic [15:0]   exp_res [NI];
  logic          exp_vld [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  circular_right_shifter #(.N(8), .S(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .a(av[0][7:0]),
    .out_valid(ov[0]), .res(r0), .mismatch(mm[0])
  );

  circular_right_shifter #(.N(16), .S(1)) u_dut16_s1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .a(av[1]),
    .out_valid(ov[1]), .res(r1), .mismatch(mm[1])
  );

  circular_right_shifter #(.N(16), .S(15)) u_dut16_s15 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .a(av[2]),
    .out_valid(ov[2]), .res(r2), .mismatch(mm[2])
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Output bit i takes input bit (i+S) mod N.
  function automatic logic [15:0] rotr_model(input logic [15:0] x, input int n, input int s);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = x[(i + s) % n];
    return r;
  endfunction

  function automatic logic [15:0] res_of(input int k);
    case (k)
      0:       return {8'h00, r0};
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  // One clock: update the expected registers from the inputs present at the edge, then check all instances.
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        exp_res[k] = '0;
        exp_vld[k] = 1'b0;
      end else begin
        exp_vld[k] = iv[k];
        if (iv[k]) exp_res[k] = rotr_model(av[k], N_ARR[k], S_ARR[k]);
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("vld%0d", k), {15'b0, ov[k]}, {15'b0, exp_vld[k]});
      chk($sformatf("res%0d", k), res_of(k), exp_res[k]);
      chk($sformatf("mis%0d", k), {15'b0, mm[k]}, 16'h0000);
    end
  endtask

  task automatic send8(input logic [7:0] x);
    iv[0] = 1'b1;
    av[0] = {8'h00, x};
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    iv  = '1;
    for (int k = 0; k < NI; k++) begin
      av[k]      = 16'hFFFF;
      exp_res[k] = '0;
      exp_vld[k] = 1'b0;
    end

    // Reset wins over in_valid.
    cycle();
    cycle();
    chk("rst_res", {8'h00, r0}, 16'h0000);
    chk("rst_vld", {15'b0, ov[0]}, 16'h0000);
    rst = 1'b0;
    iv  = '0;
    cycle();
    chk("post_rst_res", {8'h00, r0}, 16'h0000);
    chk("post_rst_vld", {15'b0, ov[0]}, 16'h0000);

    // Walking one.
    send8(8'b1000_0000); chk("walk_80", {8'h00, r0}, 16'h0010);
    send8(8'b0000_0100); chk("walk_04", {8'h00, r0}, 16'h0080);
    send8(8'b0000_0001); chk("walk_01", {8'h00, r0}, 16'h0020);

    // Mixed patterns back to back.
    send8(8'b1011_0101); chk("mix_b5", {8'h00, r0}, 16'h00B6); chk("mix_v0", {15'b0, ov[0]}, 16'h0001);
    send8(8'b0110_1100); chk("mix_6c", {8'h00, r0}, 16'h008D); chk("mix_v1", {15'b0, ov[0]}, 16'h0001);
    send8(8'b1101_0001); chk("mix_d1", {8'h00, r0}, 16'h003A); chk("mix_v2", {15'b0, ov[0]}, 16'h0001);
    send8(8'b0011_0100); chk("mix_34", {8'h00, r0}, 16'h0086); chk("mix_v3", {15'b0, ov[0]}, 16'h0001);

    // Invariant patterns.
    send8(8'h00); chk("inv_00", {8'h00, r0}, 16'h0000);
    send8(8'hFF); chk("inv_ff", {8'h00, r0}, 16'h00FF);
    send8(8'h66); chk("inv_66", {8'h00, r0}, 16'h00CC);

    // Hold with in_valid low while a toggles.
    send8(8'hF0); chk("hold_acc", {8'h00, r0}, 16'h001E);
    iv[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      av[0] = (j % 2 == 0) ? 16'h00A5 : 16'h005A;
      cycle();
      chk("hold_res", {8'h00, r0}, 16'h001E);
      chk("hold_vld", {15'b0, ov[0]}, 16'h0000);
    end

    // Reset together with in_valid.
    rst   = 1'b1;
    iv[0] = 1'b1;
    av[0] = 16'h00FF;
    cycle();
    chk("rst_pri_res", {8'h00, r0}, 16'h0000);
    rst = 1'b0;
    iv  = '0;
    cycle();

    // 16-bit instances at the distance extremes.
    iv[1] = 1'b1; av[1] = 16'h0001;
    iv[2] = 1'b1; av[2] = 16'h0001;
    cycle();
    chk("n16_s1", r1, 16'h8000);
    chk("n16_s15", r2, 16'h0002);
    iv = '0;

    // Random traffic with occasional reset.
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < NI; k++) begin
        iv[k] = ($urandom_range(0, 3) != 0);
        av[k] = 16'($urandom);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/circular_right_shifter.md
# circular_right_shifter

Registered, parameterized circular right rotator: each accepted N-bit word is rotated right by a fixed S bit positions. The result appears one clock later with a valid strobe. The block sits in the datapath wherever a constant-distance rotate is needed. It computes the rotation by bit-slice concatenation and can optionally cross-check that result against an OR-of-shifts implementation.

## Interface
- `N`, default 8: data width in bits.
- `S`, default 3: rotate distance; legal range 0 < S < N. Elaboration fails with a fatal error outside this range.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  qualifies `a` in the current cycle.
- `a`  input  N  operand.
- `out_valid`  output  1  `res` holds a new result this cycle.
- `res`  output  N  rotated result, registered.
- `mismatch`  output  1  cross-check failure flag, registered; constant 0 when the checker is compiled out.

## Operation
- Rotate definition: `res[i] = a[(i+S) mod N]` for every bit i.
  - Bits shifted out of the LSB end re-enter at the MSB end.
  - Example, N=8, S=3: ABCDEFGH -> FGHABCDE.
- Primary path (always present): concatenation `{a[S-1:0], a[N-1:S]}`.
- Check path (only with `ROTR_CROSS_CHECK_EN`): `(a >> S) | (a << (N-S))`, evaluated at width N with the overflow bits discarded.
- Both paths are purely combinational in front of the output register. No arithmetic or carry is involved; widths are N throughout.
- Valid handling:
  - `in_valid`=1 captures the primary-path result into `res` and sets `out_valid`.
  - `in_valid`=0 clears `out_valid`; `res` holds its last value.
- Back-to-back `in_valid` is accepted every cycle. There is no backpressure and no stall.
- Values of `a` while `in_valid`=0 are ignored.
- The result is independent of X/Z only when `a` is fully known. The bench compares with `===`.

## Timing
- Latency: exactly 1 cycle. A sample accepted at edge k appears on `res`/`out_valid` after edge k.
- Throughput: 1 word per cycle.
- Reset values: `res`=0, `out_valid`=0, `mismatch`=0.
- `rst` has priority over `in_valid` on the same edge. The in-flight word is discarded; nothing is presented after reset deasserts until a new `in_valid`.
- `out_valid` is a one-cycle pulse per accepted word. Consecutive accepted words keep it high continuously.
- `mismatch` updates on the same edge as `res`:
  - for an accepted word, it is set to (primary != check);
  - otherwise it is cleared.
  - It is not sticky.

## Configuration
- Macro: `ROTR_CROSS_CHECK_EN`.
- Defined:
  - the OR-of-shifts path and a comparator are instantiated;
  - `mismatch` reflects the registered comparison;
  - `res` always comes from the concatenation path.
- Undefined:
  - only the concatenation path exists;
  - `mismatch` is tied to 0;
  - `res`/`out_valid` behaviour is identical.

## Test plan
- Reset: hold `rst`=1 with `in_valid`=1, `a`=8'hFF for 2 cycles -> `res`=0, `out_valid`=0, `mismatch`=0. Deassert `rst` with `in_valid`=0 -> outputs stay 0.
- Walking one, N=8/S=3:
  - `a`=10000000 -> `res`=00010000 one cycle later;
  - `a`=00000100 -> 10000000;
  - `a`=00000001 -> 00100000.
- Mixed patterns, back-to-back one per cycle:
  - 10110101 -> 10110110;
  - 01101100 -> 10001101;
  - 11010001 -> 00111010;
  - 00110100 -> 10000110.
  - Expect `out_valid` high for 4 consecutive cycles and `mismatch`=0 throughout.
- Invariants:
  - 00000000 -> 00000000 and 11111111 -> 11111111;
  - 01100110 -> 11001100.
- Hold/reset priority:
  - Accept 11110000 (-> 00011110), then drop `in_valid` for 3 cycles while toggling `a` -> `res` stays 00011110 and `out_valid`=0.
  - Assert `rst` together with `in_valid` -> `res`=0.
- Configuration/parameters:
  - Rerun the walking-one scenario with and without `ROTR_CROSS_CHECK_EN` -> identical `res`, `mismatch`=0 throughout.
  - N=16, S=1: `a`=16'h0001 -> 16'h8000.
  - N=16, S=15: `a`=16'h0001 -> 16'h0002.
